// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake bundle between the core and the iterative multiply/divide unit.
// The core drives the request side (master); the unit answers with busy/done/out (slave).
interface muldiv_unit_if #(parameter int Size = 32);
   logic            start;
   logic [2:0]      funct3;
   logic [Size-1:0] a;
   logic [Size-1:0] b;
   logic            kill;
   logic            busy;
   logic            done;
   logic [Size-1:0] out;

   modport master (output start, funct3, a, b, kill, input busy, done, out);
   modport slave  (input start, funct3, a, b, kill, output busy, done, out);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide over operand
// magnitudes, with sign correction applied in a final FIX state before the DONE pulse.
module muldiv_unit #(
   parameter int Size = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_unit_if.slave bus
);
   localparam int CntW = (Size > 1) ? $clog2(Size) : 1;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [Size-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, out_q, out_d;
   logic [2:0]      fn_q, fn_d;
   logic            sa_q, sa_d, sb_q, sb_d;

   logic              accept, special, signed_a, signed_b, a_min, b_zero, last, div_ge;
   logic [Size-1:0]   mag_a, mag_b, quo_s, rem_s;
   logic [Size:0]     mul_sum, div_shift;
   logic [2*Size-1:0] prod_s;

   // Operand decode and the per-step arithmetic shared by CALC and FIX.
   always_comb begin
      accept    = bus.start && !bus.kill;
      signed_a  = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                  (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
      signed_b  = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) || (bus.funct3 == F_REM);
      mag_a     = (signed_a && bus.a[Size-1]) ? -bus.a : bus.a;
      mag_b     = (signed_b && bus.b[Size-1]) ? -bus.b : bus.b;
      a_min     = (bus.a == {1'b1, {(Size-1){1'b0}}});
      b_zero    = (bus.b == '0);
      special   = bus.funct3[2] && (b_zero || (!bus.funct3[0] && a_min && (&bus.b)));
      last      = (cnt_q == CntW'(Size-1));
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[Size-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      prod_s    = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
      quo_s     = (sa_q ^ sb_q) ? -lo_q : lo_q;
      rem_s     = sa_q ? -hi_q : hi_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = special ? DONE : CALC;
         CALC:    if (bus.kill) state_d = IDLE; else if (last) state_d = FIX;
         FIX:     state_d = bus.kill ? IDLE : DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
      out_d  = out_q;
      fn_d   = fn_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      case (state_q)
         IDLE: if (accept) begin
            fn_d  = bus.funct3;
            sa_d  = signed_a && bus.a[Size-1];
            sb_d  = signed_b && bus.b[Size-1];
            cnt_d = '0;
            hi_d  = '0;
            // lo holds the dividend (divide) or multiplier (multiply); opnd the other operand.
            lo_d   = bus.funct3[2] ? mag_a : mag_b;
            opnd_d = bus.funct3[2] ? mag_b : mag_a;
            if (special) begin
               if (b_zero) out_d = bus.funct3[1] ? bus.a : '1;
               else        out_d = bus.funct3[1] ? '0 : bus.a;
            end
         end
         CALC: if (!bus.kill) begin
            cnt_d = cnt_q + 1'b1;
            if (fn_q[2]) begin
               hi_d = div_ge ? Size'(div_shift - {1'b0, opnd_q}) : div_shift[Size-1:0];
               lo_d = {lo_q[Size-2:0], div_ge};
            end else begin
               hi_d = mul_sum[Size:1];
               lo_d = {mul_sum[0], lo_q[Size-1:1]};
            end
         end
         FIX: if (!bus.kill) begin
            case (fn_q)
               F_MUL:                    out_d = prod_s[Size-1:0];
               F_MULH, F_MULHSU, F_MULHU: out_d = prod_s[2*Size-1:Size];
               F_DIV, F_DIVU:            out_d = quo_s;
               default:                  out_d = rem_s;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         out_q  <= '0;
         fn_q   <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
         out_q  <= out_d;
         fn_q   <= fn_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
      end
   end

   always_comb begin
      bus.busy = (state_q != IDLE);
      bus.done = (state_q == DONE);
   end

   assign bus.out = out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a negedge monitor
// pops and compares value and arrival cycle on every done pulse.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      logic [31:0] val;
      int          at;
   } exp_t;
   exp_t exp_q[$];

   muldiv_unit_if #(.Size(32)) bus ();

   muldiv_unit #(.Size(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
      longint sx, sy, ux, uy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      case (f)
         3'd0: begin p = 64'(ux * uy); return p[31:0]; end
         3'd1: begin p = 64'(sx * sy); return p[63:32]; end
         3'd2: begin p = 64'(sx * uy); return p[63:32]; end
         3'd3: begin p = 64'(ux * uy); return p[63:32]; end
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            return 32'(sx / sy);
         end
         3'd5: begin
            if (y == 0) return 32'hFFFF_FFFF;
            return 32'(ux / uy);
         end
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sx % sy);
         end
         default: begin
            if (y == 0) return x;
            return 32'(ux % uy);
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      return f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: out=%h at cycle %0d with nothing outstanding", bus.out, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", bus.out, e.val);
            check("done_cycle", 32'(cyc), 32'(e.at));
            $display("txn: out=%h expected=%h cycle=%0d", bus.out, e.val, cyc);
         end
      end
   end

   task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv);
      int n, lat, busy_cnt;
      bit seen;
      lat = is_special(f, x, y) ? 1 : 34;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = f; bus.a = x; bus.b = y;
      n = cyc;
      exp_q.push_back('{expv, n + lat});
      @(negedge clk);
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.funct3 = 3'($urandom);
      busy_cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL timeout: no done for funct3=%0d a=%h b=%h", f, x, y);
      end else begin
         check("busy_cycles", 32'(busy_cnt), 32'(lat));
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] pool [5];
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int n;
      logic [2:0] f;
      logic [31:0] x, y;
      bus.start = 1'b0; bus.funct3 = 3'd0; bus.a = '0; bus.b = '0; bus.kill = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'h0);
      check("reset_done", 32'(bus.done), 32'h0);
      check("reset_out", bus.out, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'h0);

      // Directed cases with hand-derived results.
      do_op(3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      do_op(3'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF);
      do_op(3'd3, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002);
      do_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      do_op(3'd5, 32'd100, 32'd7, 32'd14);
      do_op(3'd7, 32'd100, 32'd7, 32'd2);
      do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
      do_op(3'd7, 32'd5, 32'd0, 32'd5);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

      // start while busy is ignored; a single done carries the original result.
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'hFFFF_FFFF; bus.b = 32'd3;
      n = cyc;
      exp_q.push_back('{32'hFFFF_FFFD, n + 34});
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < n + 10) @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd3; bus.a = 32'd5; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < n + 40) @(negedge clk);

      // kill in CALC: no done, busy drops next cycle, out keeps the previous result.
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
      n = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < n + 15) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill_busy", 32'(bus.busy), 32'h0);
      check("kill_out", bus.out, 32'hFFFF_FFFD);
      while (cyc < n + 40) @(negedge clk);

      // kill together with start in IDLE suppresses the start.
      bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd2; bus.b = 32'd2;
      @(negedge clk);
      bus.start = 1'b0; bus.kill = 1'b0;
      check("kill_start_busy", 32'(bus.busy), 32'h0);
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-divide clears outputs immediately.
      bus.start = 1'b1; bus.funct3 = 3'd4; bus.a = 32'd1000; bus.b = 32'd3;
      n = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < n + 20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_out", bus.out, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd6, 32'd7, 32'd42);

      // Randomized operations against the reference model.
      for (int i = 0; i < 150; i++) begin
         f = 3'($urandom_range(0, 7));
         x = pick();
         y = pick();
         do_op(f, x, y, ref_model(f, x, y));
      end

      repeat (5) @(negedge clk);
      check("outstanding", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Executes the eight M-extension operations selected by funct3, using a start/busy/done handshake.
- The core stalls while busy is high and captures out on the done pulse.
- Multiply uses shift-add over magnitudes; divide uses restoring division over magnitudes; sign correction happens in a dedicated final state.

Parameters:
Size, 32, operand and result width in bits (iteration count equals Size)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  Size  rs1 operand, sampled with start
b  input  Size  rs2 operand, sampled with start
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, high exactly when state == DONE
out  output  Size  registered result; valid while done is high; holds until the next result is written

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, done=0, busy=0, counter, accumulators and captured operands cleared. Reset mid-operation discards the operation with no done pulse.
- States:
  - IDLE: start=1 latches funct3, the operand signs, and the magnitudes |a| and |b|.
    - Signed view: DIV/REM/MULH use a and b; MULHSU uses a only.
    - Magnitudes fit in Size unsigned bits, so |-2^(Size-1)| = 2^(Size-1).
    - Next state is DONE if a special case applies, else CALC with counter=0.
  - CALC: one shift-add or restore step per cycle for Size cycles, then FIX.
    - Multiply: 2*Size-bit product of the magnitudes.
    - Divide: Size-bit quotient and remainder of the magnitudes.
  - FIX: apply sign correction (two's-complement negate) and select the result into out.
    - Product sign = sa^sb for MULH and sa for MULHSU; the product is negated over the full 2*Size bits.
    - Quotient sign = sa^sb; remainder sign = sa.
    - MUL returns product[Size-1:0]; MULH/MULHSU/MULHU return product[2*Size-1:Size].
  - DONE: done=1 for one cycle, then IDLE.
- Latency: start high in cycle n:
  - normal result in DONE in cycle n+Size+2;
  - special case in DONE in cycle n+1.
- Special cases (out written on the IDLE->DONE transition):
  - b==0: DIV and DIVU give all ones; REM and REMU give a.
  - a==-2^(Size-1) and b==-1: DIV gives a; REM gives 0.
- start while busy=1 (including the DONE cycle) is ignored and not queued. The earliest back-to-back start is cycle n+Size+3.
- kill=1 in CALC or FIX: go to IDLE next cycle with no done pulse; out is unchanged. kill in IDLE or DONE has no effect.
- kill and start high together in IDLE: start is ignored.
- Operands are not re-sampled mid-operation; a and b may change freely after the start cycle.

Test Plan:
- a=0xFFFFFFFF, b=3, start in cycle n:
  - MUL -> 0xFFFFFFFD, done in cycle n+34, busy high cycles n+1..n+34;
  - MULH -> 0xFFFFFFFF;
  - MULHU -> 0x00000002.
- MULHSU a=0xFFFFFFFE, b=0xFFFFFFFF -> 0xFFFFFFFE. MULH a=0x80000000, b=0x80000000 -> 0x40000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Divide-by-zero and overflow, each with done in cycle n+1:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- start pulsed at cycle n+10 during a MUL -> ignored, single done at n+34 with the original result. kill at n+15 -> no done, busy low at n+16, out retains its previous value.
- rst_n low at n+20 of a DIV -> outputs 0 immediately. A new MUL 6*7 started after release -> 42, with full latency.
